// File: rtl/cla_pkg.sv
// Shared constants, 4-bit group lookahead helpers and the per-stage control record
// for the pipelined CLA adder.
package cla_pkg;

    localparam int CLA_GROUP = 4;

    typedef struct packed {
        logic p;
        logic g;
    } cla_pg_t;

    // Control half of a stage register; the width-parameterised operand and
    // partial-sum vectors sit beside it in the top level.
    typedef struct packed {
        logic valid;
        logic carry;
    } cla_stage_t;

    function automatic cla_pg_t cla_group_pg(input logic [CLA_GROUP-1:0] a,
                                             input logic [CLA_GROUP-1:0] b);
        logic [CLA_GROUP-1:0] p;
        logic [CLA_GROUP-1:0] g;
        cla_pg_t r;
        p   = a ^ b;
        g   = a & b;
        r.p = &p;
        r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

    function automatic logic [CLA_GROUP-1:0] cla_group_sum(input logic [CLA_GROUP-1:0] a,
                                                           input logic [CLA_GROUP-1:0] b,
                                                           input logic                 ci);
        logic [CLA_GROUP-1:0] p;
        logic [CLA_GROUP-1:0] g;
        logic [CLA_GROUP-1:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return p ^ c;
    endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-lookahead adder: 4-bit P/G groups feeding a
// second-level lookahead unit, so group carries never ripple.
module cla_segment
    import cla_pkg::*;
#(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    localparam int NG = SEG / CLA_GROUP;

    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        cla_pg_t pg;
        assign pg    = cla_group_pg(a[g*CLA_GROUP +: CLA_GROUP], b[g*CLA_GROUP +: CLA_GROUP]);
        assign gp[g] = pg.p;
        assign gg[g] = pg.g;
        assign sum[g*CLA_GROUP +: CLA_GROUP] =
            cla_group_sum(a[g*CLA_GROUP +: CLA_GROUP], b[g*CLA_GROUP +: CLA_GROUP], gc[g]);
    end

    // Each group carry is a flat sum of products over the lower groups' P/G.
    always_comb begin
        logic term;
        logic c;
        gc   = '0;
        term = 1'b0;
        c    = 1'b0;
        for (int j = 0; j <= NG; j++) begin
            term = cin;
            for (int i = 0; i < j; i++) term = term & gp[i];
            c = term;
            for (int i = 0; i < j; i++) begin
                term = gg[i];
                for (int k = i + 1; k < j; k++) term = term & gp[k];
                c = c | term;
            end
            gc[j] = c;
        end
    end

    assign cout  = gc[NG];
    // sum = a ^ b ^ carry_in, so the carry into the top bit falls out of the sum.
    assign c_msb = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor, one SEG-bit segment per stage with registered
// inter-segment carry. Define CLA_PIPE_OVF_EN to add the signed-overflow output.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int SEG = WIDTH / STAGES;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    cla_stage_t       stg    [STAGES];
    cla_stage_t       stg_d  [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic [WIDTH-1:0] psum_q [STAGES];
    logic [WIDTH-1:0] a_d    [STAGES];
    logic [WIDTH-1:0] b_d    [STAGES];
    logic [WIDTH-1:0] psum_d [STAGES];
    logic [SEG-1:0]   seg_a  [STAGES];
    logic [SEG-1:0]   seg_b  [STAGES];
    logic [SEG-1:0]   seg_sum[STAGES];
    logic             seg_c  [STAGES];
    logic             seg_cout[STAGES];
`ifdef CLA_PIPE_OVF_EN
    logic             seg_cmsb[STAGES];
    logic             ovf_q;
`else
    logic             seg_cmsb_unused[STAGES];
`endif

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign c_eff    = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic             vld_in;
        logic [WIDTH-1:0] psum_base;
        logic [WIDTH-1:0] seg_ext;

        if (k == 0) begin : g_first
            assign seg_a[k]  = a[SEG-1:0];
            assign seg_b[k]  = b_eff[SEG-1:0];
            assign seg_c[k]  = c_eff;
            assign a_d[k]    = a;
            assign b_d[k]    = b_eff;
            assign vld_in    = in_valid;
            assign psum_base = '0;
        end else begin : g_next
            assign seg_a[k]  = a_q[k-1][k*SEG +: SEG];
            assign seg_b[k]  = b_q[k-1][k*SEG +: SEG];
            assign seg_c[k]  = stg[k-1].carry;
            assign a_d[k]    = a_q[k-1];
            assign b_d[k]    = b_q[k-1];
            assign vld_in    = stg[k-1].valid;
            assign psum_base = psum_q[k-1];
        end

        cla_segment #(.SEG(SEG)) u_seg (
            .a     (seg_a[k]),
            .b     (seg_b[k]),
            .cin   (seg_c[k]),
            .sum   (seg_sum[k]),
            .cout  (seg_cout[k]),
`ifdef CLA_PIPE_OVF_EN
            .c_msb (seg_cmsb[k])
`else
            .c_msb (seg_cmsb_unused[k])
`endif
        );

        // Bits above segment k are still zero here, so OR-ing places the new slice.
        assign seg_ext   = WIDTH'(seg_sum[k]) << (k * SEG);
        assign psum_d[k] = psum_base | seg_ext;
        assign stg_d[k]  = {vld_in, seg_cout[k]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stg[k]    <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                psum_q[k] <= '0;
            end
`ifdef CLA_PIPE_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                stg[k]    <= stg_d[k];
                a_q[k]    <= a_d[k];
                b_q[k]    <= b_d[k];
                psum_q[k] <= psum_d[k];
            end
`ifdef CLA_PIPE_OVF_EN
            ovf_q <= seg_cmsb[STAGES-1] ^ seg_cout[STAGES-1];
`endif
        end
    end

    assign out_valid = stg[STAGES-1].valid;
    assign sum       = psum_q[STAGES-1];
    assign cout      = stg[STAGES-1].carry;
`ifdef CLA_PIPE_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (WIDTH=32, STAGES=2);
// overflow checks are active when CLA_PIPE_OVF_EN is defined.
module tb_cla_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_PIPE_OVF_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;

    cla_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_PIPE_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat into an empty pipe: not visible after the first edge, visible after the second.
    task automatic run(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic vc, input logic vs, input logic [31:0] es,
                       input logic ec, input logic eo);
        a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        tick();
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef CLA_PIPE_OVF_EN
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) $display("note: unexpected X overflow expectation in %s", tag);
`endif
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        run("carry_cross", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run("sub_borrow",  32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run("sub_noborrow_cin_ignored", 32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0);
        run("cin_cross", 32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        run("mixed", 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0);
        run("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Back-to-back stream: result i-1 must be on the output after edge i.
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                a = 32'(i); b = 32'(i); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                chk($sformatf("stream_vld_%0d", i - 1), 64'(out_valid), 64'd1);
                chk($sformatf("stream_sum_%0d", i - 1), 64'(sum), 64'(2 * (i - 1)));
            end
        end
        tick();
        chk("stream_drain", 64'(out_valid), 64'd0);

        // Stall with two beats in flight and a third waiting at the input.
        a = 32'd1; b = 32'd100; in_valid = 1'b1;
        tick();
        a = 32'd2; b = 32'd200;
        tick();
        chk("stall_first", 64'(sum), 64'd101);
        out_ready = 1'b0;
        a = 32'd3; b = 32'd300;
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_vld_%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("stall_sum_%0d", i), 64'(sum), 64'd101);
            chk($sformatf("stall_cout_%0d", i), 64'(cout), 64'd0);
            chk($sformatf("stall_rdy_%0d", i), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("release_sum_1", 64'(sum), 64'd202);
        chk("release_vld_1", 64'(out_valid), 64'd1);
        tick();
        chk("release_sum_2", 64'(sum), 64'd303);
        chk("release_vld_2", 64'(out_valid), 64'd1);
        tick();
        chk("release_drain", 64'(out_valid), 64'd0);

        // Reset with two beats in flight.
        a = 32'd10; b = 32'd10; in_valid = 1'b1;
        tick();
        a = 32'd20; b = 32'd20;
        tick();
        in_valid = 1'b0;
        chk("midrst_pre_vld", 64'(out_valid), 64'd1);
        chk("midrst_pre_sum", 64'(sum), 64'd20);
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst_after_1", 64'(out_valid), 64'd0);
        tick();
        chk("midrst_after_2", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
